// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring shift-subtract step per cycle.
// Operands are latched as magnitudes at launch, and the sign fix-up is applied in a final cycle.
//
// state | meaning
// IDLE  | waiting; accepts Start or MTHI/MTLO writes
// CALC  | WIDTH iteration steps, counter WIDTH-1 down to 0
// FIX   | sign correction, Hi/Lo write, Done/DivByZero raised for the next cycle
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] HiLoWrData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} stateType;

    stateType         state, nextState;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] absA, absB, accHi, accLo, hiReg, loReg;
    logic             isDiv, signA, negRes, divZero, doneReg, dbzReg;
    logic             srcANeg, srcBNeg;
    logic [WIDTH-1:0] magA, magB, addend, remDiff, fixHi, fixLo;
    logic [WIDTH:0]   mulSum, remShift;
    logic             remGeq;
    logic [2*WIDTH-1:0] prodMag, prodFix;

    // Op[0] set means unsigned, so no operand is treated as negative.
    assign srcANeg = ~Op[0] & SrcA[WIDTH-1];
    assign srcBNeg = ~Op[0] & SrcB[WIDTH-1];
    assign magA    = srcANeg ? -SrcA : SrcA;
    assign magB    = srcBNeg ? -SrcB : SrcB;

    assign Busy      = (state != IDLE);
    assign Done      = doneReg;
    assign DivByZero = dbzReg;
    assign Hi        = hiReg;
    assign Lo        = loReg;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (Start) nextState = CALC;
            CALC:    if (count == '0) nextState = FIX;
            FIX:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        addend   = accLo[0] ? absA : {WIDTH{1'b0}};
        mulSum   = {1'b0, accHi} + {1'b0, addend};
        remShift = {accHi, accLo[WIDTH-1]};
        remGeq   = (remShift >= {1'b0, absB});
        remDiff  = remShift[WIDTH-1:0] - absB;
        prodMag  = {accHi, accLo};
        prodFix  = negRes ? -prodMag : prodMag;
        fixHi    = prodFix[2*WIDTH-1:WIDTH];
        fixLo    = prodFix[WIDTH-1:0];
        if (isDiv) begin
            // A zero divisor leaves the dividend untouched in Hi and an all-ones quotient.
            if (divZero) begin
                fixHi = signA ? -absA : absA;
                fixLo = {WIDTH{1'b1}};
            end else begin
                fixHi = signA ? -accHi : accHi;
                fixLo = negRes ? -accLo : accLo;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count   <= '0;
            absA    <= '0;
            absB    <= '0;
            accHi   <= '0;
            accLo   <= '0;
            hiReg   <= '0;
            loReg   <= '0;
            isDiv   <= 1'b0;
            signA   <= 1'b0;
            negRes  <= 1'b0;
            divZero <= 1'b0;
            doneReg <= 1'b0;
            dbzReg  <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            dbzReg  <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        absA    <= magA;
                        absB    <= magB;
                        isDiv   <= Op[1];
                        signA   <= srcANeg;
                        negRes  <= srcANeg ^ srcBNeg;
                        divZero <= Op[1] && (SrcB == '0);
                        count   <= CW'(WIDTH - 1);
                        accHi   <= '0;
                        accLo   <= Op[1] ? magA : magB;
                    end else begin
                        if (HiWrite) hiReg <= HiLoWrData;
                        if (LoWrite) loReg <= HiLoWrData;
                    end
                end
                CALC: begin
                    if (isDiv) begin
                        if (remGeq) begin
                            accHi <= remDiff;
                            accLo <= {accLo[WIDTH-2:0], 1'b1};
                        end else begin
                            accHi <= remShift[WIDTH-1:0];
                            accLo <= {accLo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        accHi <= mulSum[WIDTH:1];
                        accLo <= {mulSum[0], accLo[WIDTH-1:1]};
                    end
                    if (count != '0) count <= count - CW'(1);
                end
                FIX: begin
                    hiReg   <= fixHi;
                    loReg   <= fixLo;
                    doneReg <= 1'b1;
                    dbzReg  <= divZero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected results queued at launch, compared at Done.
module tb_mult_div_unit;
    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Rst_n, Start, HiWrite, LoWrite;
    logic [1:0]   Op;
    logic [W-1:0] SrcA, SrcB, HiLoWrData;
    logic         Busy, Done, DivByZero;
    logic [W-1:0] Hi, Lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        string       name;
    } resT;

    resT sb[$];

    mult_div_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
        .HiWrite(HiWrite), .LoWrite(LoWrite), .HiLoWrData(HiLoWrData),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    function automatic resT model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        resT r;
        longint sa, sb2, p, q, m;
        longint unsigned ua, ub, up, uq, um;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        r.dbz  = 1'b0;
        r.name = "rand";
        r.hi   = '0;
        r.lo   = '0;
        case (op)
            2'b00: begin p = sa * sb2; r.hi = p[63:32]; r.lo = p[31:0]; end
            2'b01: begin up = ua * ub; r.hi = up[63:32]; r.lo = up[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    r.hi = a; r.lo = 32'hFFFF_FFFF; r.dbz = 1'b1;
                end else if (op == 2'b10) begin
                    q = sa / sb2; m = sa % sb2; r.lo = q[31:0]; r.hi = m[31:0];
                end else begin
                    uq = ua / ub; um = ua % ub; r.lo = uq[31:0]; r.hi = um[31:0];
                end
            end
        endcase
        return r;
    endfunction

    // Called at a falling edge; the next rising edge is E0.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eHi, input logic [31:0] eLo, input logic eDbz,
                          input string name);
        resT e;
        e.hi = eHi; e.lo = eLo; e.dbz = eDbz; e.name = name;
        sb.push_back(e);
        Start = 1'b1; Op = op; SrcA = a; SrcB = b;
        @(negedge Clk);
        Start = 1'b0;
        Op = 2'($urandom_range(0, 3));
        SrcA = $urandom;
        SrcB = $urandom;
    endtask

    task automatic waitDone(input int expBusy);
        int   busyCnt = 0;
        int   cyc = 0;
        logic dbzEarly = 1'b0;
        resT  e;
        while (Done !== 1'b1 && cyc < 200) begin
            if (Busy === 1'b1) busyCnt++;
            if (DivByZero === 1'b1) dbzEarly = 1'b1;
            @(negedge Clk);
            cyc++;
        end
        checks++;
        if (Done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: Done=%b after %0d cycles, required 1", Done, cyc);
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: Done seen with %0d results pending, required 1", sb.size());
            return;
        end
        e = sb.pop_front();
        checks++;
        if (busyCnt !== expBusy) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d required %0d", e.name, busyCnt, expBusy);
        end
        checks++;
        if (Hi !== e.hi) begin
            errors++;
            $display("FAIL %s hi: got %h required %h", e.name, Hi, e.hi);
        end
        checks++;
        if (Lo !== e.lo) begin
            errors++;
            $display("FAIL %s lo: got %h required %h", e.name, Lo, e.lo);
        end
        checks++;
        if (DivByZero !== e.dbz || dbzEarly !== 1'b0) begin
            errors++;
            $display("FAIL %s divbyzero: got %b (early %b) required %b", e.name, DivByZero, dbzEarly, e.dbz);
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: got %b required 0", e.name, Busy);
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
        Op = 2'b00; SrcA = '0; SrcB = '0; HiLoWrData = '0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({Busy, Done, DivByZero} !== 3'b000 || Hi !== 32'd0 || Lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy/done/dbz=%b%b%b hi=%h lo=%h required 000 0 0", Busy, Done, DivByZero, Hi, Lo);
        end
        Rst_n = 1'b1;
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || Hi !== 32'd0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b hi=%h required 0 0", Busy, Hi);
        end
    endtask

    task automatic test_mult();
        launch(2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mult_neg1x2");
        waitDone(33);
        @(negedge Clk);
        checks++;
        if (Done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: got %b required 0", Done);
        end
        launch(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, "multu_max_x2");
        waitDone(33);
        launch(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mult_minxmin");
        waitDone(33);
    endtask

    task automatic test_divide();
        launch(2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, "divu_7_2");
        waitDone(33);
        launch(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
        waitDone(33);
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, "div_min_m1");
        waitDone(33);
        launch(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, "div_7_m2");
        waitDone(33);
    endtask

    task automatic test_div_by_zero();
        launch(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, "divu_5_0");
        waitDone(33);
        @(negedge Clk);
        checks++;
        if (DivByZero !== 1'b0) begin
            errors++;
            $display("FAIL divbyzero_pulse_width: got %b required 0", DivByZero);
        end
        launch(2'b10, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, "div_m16_0");
        waitDone(33);
    endtask

    task automatic test_busy_ignore();
        logic [31:0] hiBefore;
        int extraDone = 0;
        hiBefore = Hi;
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_busy_ignore");
        repeat (4) @(negedge Clk);
        Start = 1'b1; HiWrite = 1'b1; HiLoWrData = 32'h1234; Op = 2'b11; SrcA = 32'd9; SrcB = 32'd3;
        @(negedge Clk);
        Start = 1'b0; HiWrite = 1'b0;
        checks++;
        if (Hi !== hiBefore) begin
            errors++;
            $display("FAIL hi_write_while_busy: got %h required %h", Hi, hiBefore);
        end
        waitDone(28);
        repeat (40) begin
            @(negedge Clk);
            if (Done === 1'b1 || Busy === 1'b1) extraDone++;
        end
        checks++;
        if (extraDone !== 0) begin
            errors++;
            $display("FAIL start_while_busy_queued: got %0d extra busy/done cycles required 0", extraDone);
        end
        checks++;
        if (Hi !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL hi_stable_idle: got %h required fffffffe", Hi);
        end
    endtask

    task automatic test_hilo_writes();
        HiWrite = 1'b1; HiLoWrData = 32'h1234;
        @(negedge Clk);
        HiWrite = 1'b0;
        checks++;
        if (Hi !== 32'h1234 || Lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL mthi: hi=%h lo=%h required 00001234 00000001", Hi, Lo);
        end
        HiWrite = 1'b1; LoWrite = 1'b1; HiLoWrData = 32'hCAFE;
        @(negedge Clk);
        HiWrite = 1'b0; LoWrite = 1'b0;
        checks++;
        if (Hi !== 32'hCAFE || Lo !== 32'hCAFE) begin
            errors++;
            $display("FAIL mthi_mtlo: hi=%h lo=%h required 0000cafe 0000cafe", Hi, Lo);
        end
        HiWrite = 1'b1; LoWrite = 1'b1; HiLoWrData = 32'hDEAD;
        launch(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, "start_wins_over_mt");
        HiWrite = 1'b0; LoWrite = 1'b0;
        checks++;
        if (Hi !== 32'hCAFE || Lo !== 32'hCAFE) begin
            errors++;
            $display("FAIL start_beats_write: hi=%h lo=%h required 0000cafe 0000cafe", Hi, Lo);
        end
        waitDone(33);
    endtask

    task automatic test_reset_abort();
        Start = 1'b1; Op = 2'b00; SrcA = 32'd5; SrcB = 32'd6;
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        @(posedge Clk);
        #1 Rst_n = 1'b0;
        #1;
        checks++;
        if ({Busy, Done, DivByZero} !== 3'b000 || Hi !== 32'd0 || Lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_abort: busy/done/dbz=%b%b%b hi=%h lo=%h required 000 0 0", Busy, Done, DivByZero, Hi, Lo);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (40) @(negedge Clk);
        checks++;
        if (Done !== 1'b0 || Hi !== 32'd0 || Lo !== 32'd0) begin
            errors++;
            $display("FAIL abort_no_result: done=%b hi=%h lo=%h required 0 0 0", Done, Hi, Lo);
        end
        launch(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, "mult_3x4_after_reset");
        waitDone(33);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op;
        logic [31:0] a, b;
        resT e;
        for (int i = 0; i < 12; i++) begin
            op = 2'(i % 4);
            a  = (i == 5) ? 32'h8000_0000 : $urandom;
            b  = (i == 7) ? 32'd0 : (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i == 9) b = 32'hFFFF_FFFF;
            e = model(op, a, b);
            launch(op, a, b, e.hi, e.lo, e.dbz, $sformatf("b2b_%0d_op%0d", i, op));
            waitDone(33);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divide();
        test_div_by_zero();
        test_busy_ignore();
        test_hilo_writes();
        test_reset_abort();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
